// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter.
// Holds the FSM state encoding, the port index type and the default memory size.
package dmem_arb_pkg;

  localparam int unsigned MEM_BYTES_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef logic port_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin grant picker, purely combinational.
// Ports: req0_i/req1_i requests, last_i previous winner; gnt_o winner, valid_o any request.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic  req0_i,
  input  logic  req1_i,
  input  port_t last_i,
  output port_t gnt_o,
  output logic  valid_o
);

  always_comb begin
    gnt_o   = 1'b0;
    valid_o = 1'b0;
    unique case (1'b1)
      (req0_i & req1_i): begin
        valid_o = 1'b1;
        gnt_o   = ~last_i;
      end
      (req0_i & ~req1_i): begin
        valid_o = 1'b1;
        gnt_o   = 1'b0;
      end
      (~req0_i & req1_i): begin
        valid_o = 1'b1;
        gnt_o   = 1'b1;
      end
      default: begin
        valid_o = 1'b0;
        gnt_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ACCESS -> RESP, round-robin on ties.
// Ports: reqN/weN/addrN/wdataN in, ackN/rdataN/errN out per requester; mem_* to the memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int unsigned NUM_REQ   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        we0_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] wdata0_i,
  output logic        ack0_o,
  output logic [31:0] rdata0_o,
  output logic        err0_o,
  input  logic        req1_i,
  input  logic        we1_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata1_i,
  output logic        ack1_o,
  output logic [31:0] rdata1_o,
  output logic        err1_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_rdata_i
);

  if (NUM_REQ != 2) begin : g_bad_num_req
    $error("dmem_arbiter supports NUM_REQ == 2 only");
  end

  // Highest byte address at which a full word still fits.
  localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);

  arb_state_e  state_q;
  port_t       last_q;
  port_t       gnt_q;
  logic        we_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  port_t       pick_gnt;
  logic        pick_vld;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_we;
  logic        sel_oob;

  dmem_rr_pick u_pick (
    .req0_i  (req0_i),
    .req1_i  (req1_i),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_vld)
  );

  always_comb begin
    sel_addr  = addr0_i;
    sel_wdata = wdata0_i;
    sel_we    = we0_i;
    if (pick_gnt) begin
      sel_addr  = addr1_i;
      sel_wdata = wdata1_i;
      sel_we    = we1_i;
    end
  end

  // Range check runs on the winner's live address so an
  // out-of-range access can skip ACCESS in the same edge.
  assign sel_oob = (sel_addr > ADDR_MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            we_q    <= sel_we;
            gnt_q   <= pick_gnt;
            last_q  <= pick_gnt;
            err_q   <= sel_oob;
            state_q <= sel_oob ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          // Read data lands in the port register at the
          // closing edge, so it is already valid with ack.
          if (!we_q) begin
            if (gnt_q) begin
              rdata1_q <= mem_rdata_i;
            end else begin
              rdata0_q <= mem_rdata_i;
            end
          end
          state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  logic in_access;
  logic in_resp;

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  assign mem_read_o  = in_access & ~we_q;
  assign mem_write_o = in_access & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign ack0_o   = in_resp & ~gnt_q;
  assign ack1_o   = in_resp & gnt_q;
  assign err0_o   = ack0_o & err_q;
  assign err1_o   = ack1_o & err_q;
  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word memory model.
// Ports: none; drives the DUT and checks acks, strobes and read data.
module tb_dmem_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic        req0_i;
  logic        we0_i;
  logic [31:0] addr0_i;
  logic [31:0] wdata0_i;
  logic        ack0_o;
  logic [31:0] rdata0_o;
  logic        err0_o;
  logic        req1_i;
  logic        we1_i;
  logic [31:0] addr1_i;
  logic [31:0] wdata1_i;
  logic        ack1_o;
  logic [31:0] rdata1_o;
  logic        err1_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_rdata_i;

  logic [31:0] mem [0:7];

  int nchk;
  int npass;
  int nfail;

  dmem_arbiter #(
    .MEM_BYTES (32),
    .NUM_REQ   (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req0_i      (req0_i),
    .we0_i       (we0_i),
    .addr0_i     (addr0_i),
    .wdata0_i    (wdata0_i),
    .ack0_o      (ack0_o),
    .rdata0_o    (rdata0_o),
    .err0_o      (err0_o),
    .req1_i      (req1_i),
    .we1_i       (we1_i),
    .addr1_i     (addr1_i),
    .wdata1_i    (wdata1_i),
    .ack1_o      (ack1_o),
    .rdata1_o    (rdata1_o),
    .err1_o      (err1_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .mem_rdata_i (mem_rdata_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  assign mem_rdata_i = mem[mem_addr_o[4:2]];

  always @(posedge clk_i) begin
    if (mem_write_o) mem[mem_addr_o[4:2]] <= mem_wdata_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    nchk  = 0;
    npass = 0;
    nfail = 0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    mem[7]   = 32'hCAFE_0007;
    rst_i    = 1'b1;
    req0_i   = 1'b0;
    we0_i    = 1'b0;
    addr0_i  = '0;
    wdata0_i = '0;
    req1_i   = 1'b0;
    we1_i    = 1'b0;
    addr1_i  = '0;
    wdata1_i = '0;
    tick();
    tick();
    rst_i = 1'b0;

    chk("rst_ack0", ack0_o, 0);
    chk("rst_ack1", ack1_o, 0);
    chk("rst_err0", err0_o, 0);
    chk("rst_err1", err1_o, 0);
    chk("rst_rd", mem_read_o, 0);
    chk("rst_wr", mem_write_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_rdata0", rdata0_o, 0);
    chk("rst_rdata1", rdata1_o, 0);

    // port 0 write 0xDEADBEEF to addr 4
    req0_i   = 1'b1;
    we0_i    = 1'b1;
    addr0_i  = 32'd4;
    wdata0_i = 32'hDEAD_BEEF;
    chk("w_t_wr", mem_write_o, 0);
    tick();
    chk("w_t1_wr", mem_write_o, 1);
    chk("w_t1_rd", mem_read_o, 0);
    chk("w_t1_addr", mem_addr_o, 32'd4);
    chk("w_t1_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    chk("w_t1_ack0", ack0_o, 0);
    tick();
    chk("w_t2_ack0", ack0_o, 1);
    chk("w_t2_err0", err0_o, 0);
    chk("w_t2_ack1", ack1_o, 0);
    chk("w_t2_wr", mem_write_o, 0);
    chk("w_t2_rdata0", rdata0_o, 0);
    req0_i = 1'b0;
    tick();
    chk("w_t3_ack0", ack0_o, 0);
    chk("w_hold_addr", mem_addr_o, 32'd4);

    // port 0 read back addr 4
    req0_i = 1'b1;
    we0_i  = 1'b0;
    tick();
    chk("r_t1_rd", mem_read_o, 1);
    chk("r_t1_wr", mem_write_o, 0);
    tick();
    chk("r_t2_ack0", ack0_o, 1);
    chk("r_t2_rdata0", rdata0_o, 32'hDEAD_BEEF);
    chk("r_t2_err0", err0_o, 0);
    req0_i = 1'b0;
    tick();
    chk("r_t3_ack0", ack0_o, 0);
    chk("r_hold_rdata0", rdata0_o, 32'hDEAD_BEEF);

    // both ports from reset: grants 0,1,0,1, one per 3 cycles
    rst_i = 1'b1;
    tick();
    rst_i   = 1'b0;
    req0_i  = 1'b1;
    we0_i   = 1'b0;
    addr0_i = 32'd4;
    req1_i  = 1'b1;
    we1_i   = 1'b0;
    addr1_i = 32'd28;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("rr_ack0_k%0d", k), ack0_o,
          (k == 2 || k == 8) ? 1 : 0);
      chk($sformatf("rr_ack1_k%0d", k), ack1_o,
          (k == 5 || k == 11) ? 1 : 0);
      chk($sformatf("rr_rd_k%0d", k), mem_read_o,
          (k % 3 == 1) ? 1 : 0);
    end
    req0_i = 1'b0;
    req1_i = 1'b0;
    chk("rr_rdata0", rdata0_o, 32'hDEAD_BEEF);
    chk("rr_rdata1", rdata1_o, 32'hCAFE_0007);
    tick();

    // port 1 read addr 29: out of range
    req1_i  = 1'b1;
    we1_i   = 1'b0;
    addr1_i = 32'd29;
    tick();
    chk("oob_ack1", ack1_o, 1);
    chk("oob_err1", err1_o, 1);
    chk("oob_ack0", ack0_o, 0);
    chk("oob_rd", mem_read_o, 0);
    chk("oob_wr", mem_write_o, 0);
    chk("oob_rdata1", rdata1_o, 32'hCAFE_0007);
    req1_i = 1'b0;
    tick();
    chk("oob_ack1_off", ack1_o, 0);
    chk("oob_err1_off", err1_o, 0);
    chk("oob_rd_after", mem_read_o, 0);

    // reset in ACCESS of a port 0 write
    req0_i   = 1'b1;
    we0_i    = 1'b1;
    addr0_i  = 32'd8;
    wdata0_i = 32'h0000_1234;
    tick();
    chk("ra_wr", mem_write_o, 1);
    rst_i  = 1'b1;
    req0_i = 1'b0;
    tick();
    rst_i = 1'b0;
    chk("ra_ack0", ack0_o, 0);
    chk("ra_wr_off", mem_write_o, 0);
    chk("ra_rd_off", mem_read_o, 0);
    chk("ra_addr", mem_addr_o, 0);
    tick();
    chk("ra_ack0_late", ack0_o, 0);
    chk("ra_wr_late", mem_write_o, 0);

    // port 0 pulses req only during port 1 RESP
    req1_i  = 1'b1;
    we1_i   = 1'b0;
    addr1_i = 32'd28;
    tick();
    chk("wd_p1_rd", mem_read_o, 1);
    tick();
    chk("wd_p1_ack1", ack1_o, 1);
    chk("wd_p1_rdata1", rdata1_o, 32'hCAFE_0007);
    req1_i  = 1'b0;
    req0_i  = 1'b1;
    we0_i   = 1'b1;
    addr0_i = 32'd12;
    tick();
    req0_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wd_ack0_%0d", k), ack0_o, 0);
      chk($sformatf("wd_wr_%0d", k), mem_write_o, 0);
      chk($sformatf("wd_rd_%0d", k), mem_read_o, 0);
      tick();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
